// File: rtl/ex_alu_unit.sv
// rtl/ex_alu_unit.sv - EX-stage ALU with serial or barrel shifter (EX_ALU_BARREL_SHIFT_EN selects barrel)
module ex_alu_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  alu_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal,
    output logic        busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;

    localparam logic [1:0] SH_NONE = 2'd0;
    localparam logic [1:0] SH_LL   = 2'd1;
    localparam logic [1:0] SH_RL   = 2'd2;
    localparam logic [1:0] SH_RA   = 2'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  shop_q, shop_d;
    logic        illegal_q, illegal_d;

    logic [31:0] alu_val;
    logic [31:0] step_val;
    logic [1:0]  shop_sel;
    logic        alu_ok;
    logic        accept;
    logic [4:0]  amt;

    assign amt       = op_b[4:0];
    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = (result_q == 32'd0);
    assign illegal   = illegal_q;
`ifdef EX_ALU_BARREL_SHIFT_EN
    assign busy      = 1'b0;
`else
    assign busy      = (state_q == SHIFT);
`endif

    // Serial build loads op_a for shifts; the shift itself runs in SHIFT.
    always_comb begin
        alu_val  = 32'd0;
        alu_ok   = 1'b1;
        shop_sel = SH_NONE;
        case (alu_sel)
            OP_ADD:  alu_val = op_a + op_b;
            OP_SUB:  alu_val = op_a - op_b;
            OP_AND:  alu_val = op_a & op_b;
            OP_OR:   alu_val = op_a | op_b;
            OP_XOR:  alu_val = op_a ^ op_b;
            OP_SLT:  alu_val = {31'd0, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_val = {31'd0, (op_a < op_b)};
`ifdef EX_ALU_BARREL_SHIFT_EN
            OP_SLL: begin shop_sel = SH_LL; alu_val = op_a << amt; end
            OP_SRL: begin shop_sel = SH_RL; alu_val = op_a >> amt; end
            OP_SRA: begin shop_sel = SH_RA; alu_val = $unsigned($signed(op_a) >>> amt); end
`else
            OP_SLL: begin shop_sel = SH_LL; alu_val = op_a; end
            OP_SRL: begin shop_sel = SH_RL; alu_val = op_a; end
            OP_SRA: begin shop_sel = SH_RA; alu_val = op_a; end
`endif
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        step_val = result_q;
        case (shop_q)
            SH_LL:   step_val = {result_q[30:0], 1'b0};
            SH_RL:   step_val = {1'b0, result_q[31:1]};
            SH_RA:   step_val = {result_q[31], result_q[31:1]};
            default: step_val = result_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        shop_d    = shop_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d   = IDLE;
            illegal_d = 1'b0;
            cnt_d     = 5'd0;
        end else if (accept) begin
            illegal_d = !alu_ok;
            result_d  = alu_ok ? alu_val : 32'd0;
            shop_d    = shop_sel;
            state_d   = DONE;
`ifndef EX_ALU_BARREL_SHIFT_EN
            if ((shop_sel != SH_NONE) && (amt != 5'd0)) begin
                cnt_d   = amt;
                state_d = SHIFT;
            end
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    result_d = step_val;
                    cnt_d    = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= 32'd0;
            cnt_q     <= 5'd0;
            shop_q    <= SH_NONE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            shop_q    <= shop_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb/tb_ex_alu_unit.sv - randomized and directed self-checking bench for ex_alu_unit
module tb_ex_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  alu_sel;
    logic [31:0] op_a, op_b;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] result;
    logic        zero, illegal, busy;

    int n_tests = 0;
    int n_fail  = 0;

    ex_alu_unit dut (
        .clk(clk), .rst_n(rst_n), .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] s);
        return s inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100,
                         4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
    endfunction

    function automatic bit ref_is_shift(input logic [3:0] s);
        return s inside {4'b0111, 4'b1000, 4'b1001};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (s)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0100: return a ^ b;
            4'b0111: return a << b[4:0];
            4'b1000: return a >> b[4:0];
            4'b1001: return sa >>> b[4:0];
            4'b1010: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1011: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] s, input logic [31:0] b);
`ifdef EX_ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (ref_is_shift(s) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    task automatic run_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b, input int stall);
        int cyc;
        int busy_cnt;
        logic [31:0] exp_r;
        exp_r = ref_alu(s, a, b);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        alu_sel = s; op_a = a; op_b = b; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; alu_sel = 4'($urandom);
        cyc = 1;
        busy_cnt = 0;
        while (!out_valid && cyc < 64) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, ref_latency(s, b));
        check("busy_cycles", busy_cnt, ref_latency(s, b) - 1);
        check("out_valid", out_valid, 1);
        check("result", result, exp_r);
        check("zero", zero, exp_r == 32'd0);
        check("illegal", illegal, !ref_legal(s));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, exp_r);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("consumed", out_valid, 0);
    endtask

    task automatic start_long_shift();
        @(negedge clk);
        alu_sel = 4'b0111; op_a = 32'h0000_0001; op_b = 32'd20;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
`ifndef EX_ALU_BARREL_SHIFT_EN
        check("shift_busy", busy, 1);
`endif
    endtask

    task automatic watch_no_pulse(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  codes [10];
        logic [3:0]  s;
        logic [31:0] a, b;
        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100,
                  4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
        rst_n = 1'b0; alu_sel = 4'd0; op_a = 32'd0; op_b = 32'd0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        run_op(4'b0110, 32'd5, 32'd5, 0);
        run_op(4'b1001, 32'h8000_0000, 32'd4, 0);
        run_op(4'b1010, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b1011, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(4'b0111, 32'h0000_00F0, 32'd0, 0);

        // Backpressure then back-to-back accept
        @(negedge clk);
        alu_sel = 4'b0010; op_a = 32'd7; op_b = 32'd8; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_valid", out_valid, 1);
        check("bp_result", result, 15);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold", result, 15);
            check("bp_in_ready", in_ready, 0);
        end
        alu_sel = 4'b0100; op_a = 32'd3; op_b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_result", result, 2);
        @(negedge clk);
        check("b2b_drain", out_valid, 0);

        start_long_shift();
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_illegal", illegal, 0);
        check("flush_in_ready", in_ready, 1);
        watch_no_pulse("flush_no_pulse");

        start_long_shift();
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_illegal", illegal, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        watch_no_pulse("mid_rst_no_pulse");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 15));
            else s = codes[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 5) == 0) ? a : $urandom;
            run_op(s, a, b, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
